// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter sizing and monitor FSM states
// for the VGA sync generator / monitor family.
package vga_timing_pkg;

    localparam int unsigned VGA_H_TOTAL = 800;
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_V_TOTAL = 525;
    localparam int unsigned VGA_V_SYNC  = 2;

    localparam int unsigned CNT_W = 11;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } mon_state_e;

    // Absolute-difference tolerance test; no wrap because the larger operand is always the minuend.
    function automatic logic out_of_tol(cnt_t meas, cnt_t nom, cnt_t tol);
        cnt_t diff;
        diff = (meas > nom) ? cnt_t'(meas - nom) : cnt_t'(nom - meas);
        return diff > tol;
    endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and measurement/status outputs of the VGA sync monitor.
// master = sync source side, slave = monitor side.
interface vga_sync_monitor_if;
    import vga_timing_pkg::*;

    logic h_sync_in;
    logic v_sync_in;
    cnt_t h_period;
    cnt_t h_width;
    cnt_t v_lines;
    cnt_t v_width;
    cnt_t x_pos;
    cnt_t y_pos;
    logic frame_strobe;
    logic locked;

    modport master (
        output h_sync_in, v_sync_in,
        input  h_period, h_width, v_lines, v_width, x_pos, y_pos, frame_strobe, locked
    );

    modport slave (
        input  h_sync_in, v_sync_in,
        output h_period, h_width, v_lines, v_width, x_pos, y_pos, frame_strobe, locked
    );

endinterface

// File: rtl/vga_sync_edge.sv
// Per-input sampler: optional 2-flop synchronizer (VGA_MON_SYNC_EN) plus the
// previous-sample register, producing level and fall/rise pulses.
module vga_sync_edge (
    input  logic clk_25,
    input  logic reset_n,
    input  logic sync_in,
    output logic level_c,
    output logic fall_c,
    output logic rise_c
);

`ifdef VGA_MON_SYNC_EN
    logic meta_q;
    logic stable_q;

    // Idle level of an active-low sync is high, so the chain resets to 1.
    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            meta_q   <= 1'b1;
            stable_q <= 1'b1;
        end else begin
            meta_q   <= sync_in;
            stable_q <= meta_q;
        end
    end

    assign level_c = stable_q;
`else
    assign level_c = sync_in;
`endif

    logic prev_q;

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_c;
        end
    end

    assign fall_c = prev_q & ~level_c;
    assign rise_c = ~prev_q & level_c;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures incoming active-low h/v sync timing and locks after LOCK_FRAMES
// consecutive in-spec frames. Define VGA_MON_SYNC_EN for asynchronous sources.
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned H_TOL       = 2,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic                clk_25,
    input  logic                reset_n,
    vga_sync_monitor_if.slave   bus
);

    localparam int unsigned GOOD_W = 4;

    localparam cnt_t              H_TOTAL_C = CNT_W'(H_TOTAL);
    localparam cnt_t              H_SYNC_C  = CNT_W'(H_SYNC);
    localparam cnt_t              V_TOTAL_C = CNT_W'(V_TOTAL);
    localparam cnt_t              V_SYNC_C  = CNT_W'(V_SYNC);
    localparam cnt_t              H_TOL_C   = CNT_W'(H_TOL);
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_FRAMES);

    logic h_fall_c, h_rise_c, h_level_c;
    logic v_fall_c, v_rise_c, v_level_c;

    vga_sync_edge u_h_edge (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .sync_in (bus.h_sync_in),
        .level_c (h_level_c),
        .fall_c  (h_fall_c),
        .rise_c  (h_rise_c)
    );

    vga_sync_edge u_v_edge (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .sync_in (bus.v_sync_in),
        .level_c (v_level_c),
        .fall_c  (v_fall_c),
        .rise_c  (v_rise_c)
    );

    logic unused_levels;
    assign unused_levels = h_level_c & v_level_c;

    cnt_t h_cnt, v_cnt;
    cnt_t h_period_q, h_width_q, v_lines_q, v_width_q;
    logic h_seen, bad;

    cnt_t h_plus_c, v_plus_c;
    logic h_sat_c, v_sat_c, lost_c;
    logic period_bad_c, width_bad_c, frame_good_c;

    // Saturating next counts; an h edge coincident with a v edge belongs to the closing measurement.
    always_comb begin
        h_plus_c     = (h_cnt == CNT_MAX) ? CNT_MAX : cnt_t'(h_cnt + cnt_t'(1));
        v_plus_c     = (h_fall_c && (v_cnt != CNT_MAX)) ? cnt_t'(v_cnt + cnt_t'(1)) : v_cnt;
        h_sat_c      = !h_fall_c && (h_cnt == cnt_t'(CNT_MAX - cnt_t'(1)));
        v_sat_c      = !v_fall_c && h_fall_c && (v_cnt == cnt_t'(CNT_MAX - cnt_t'(1)));
        lost_c       = h_sat_c | v_sat_c;
        period_bad_c = h_fall_c & h_seen & out_of_tol(h_plus_c, H_TOTAL_C, H_TOL_C);
        width_bad_c  = h_rise_c & h_seen & out_of_tol(h_plus_c, H_SYNC_C, H_TOL_C);
        frame_good_c = !(bad | period_bad_c | width_bad_c)
                       && (v_plus_c == V_TOTAL_C) && (v_width_q == V_SYNC_C);
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_period_q <= '0;
            h_width_q  <= '0;
            v_lines_q  <= '0;
            v_width_q  <= '0;
            h_seen     <= 1'b0;
            bad        <= 1'b0;
        end else begin
            h_cnt <= h_fall_c ? '0 : h_plus_c;
            v_cnt <= v_fall_c ? '0 : v_plus_c;
            if (h_fall_c && h_seen) h_period_q <= h_plus_c;
            if (h_rise_c && h_seen) h_width_q  <= h_plus_c;
            if (v_fall_c)           v_lines_q  <= v_plus_c;
            if (v_rise_c)           v_width_q  <= v_plus_c;
            if (lost_c)             h_seen <= 1'b0;
            else if (h_fall_c)      h_seen <= 1'b1;
            if (lost_c || v_fall_c)                 bad <= 1'b0;
            else if (period_bad_c || width_bad_c)   bad <= 1'b1;
        end
    end

    mon_state_e        state, state_d;
    logic [GOOD_W-1:0] good_cnt, good_cnt_d;
    logic              strobe_d;
    logic              strobe_q, locked_q;

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
            strobe_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_d;
            good_cnt <= good_cnt_d;
            strobe_q <= strobe_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    // Frame evaluation at each v falling edge; loss of sync overrides everything.
    always_comb begin
        state_d    = state;
        good_cnt_d = good_cnt;
        strobe_d   = 1'b0;
        if (lost_c) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
        end else if (v_fall_c) begin
            unique case (state)
                SEARCH: begin
                    state_d    = CHECK;
                    good_cnt_d = '0;
                end
                CHECK: begin
                    strobe_d = 1'b1;
                    if (frame_good_c) begin
                        good_cnt_d = GOOD_W'(good_cnt + GOOD_W'(1));
                        if (good_cnt_d == LOCK_C) state_d = LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    strobe_d = 1'b1;
                    if (!frame_good_c) begin
                        state_d    = CHECK;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.h_period     = h_period_q;
    assign bus.h_width      = h_width_q;
    assign bus.v_lines      = v_lines_q;
    assign bus.v_width      = v_width_q;
    assign bus.x_pos        = h_cnt;
    assign bus.y_pos        = v_cnt;
    assign bus.frame_strobe = strobe_q;
    assign bus.locked       = locked_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor using scaled-down timing (40x12 frames)
// and a frame-level scoreboard popped on every frame_strobe.
module tb_vga_sync_monitor;

    localparam int HT  = 40;
    localparam int HS  = 6;
    localparam int VT  = 12;
    localparam int VS  = 2;
    localparam int TOL = 2;
    localparam int LF  = 4;

    logic clk_25  = 1'b0;
    logic reset_n = 1'b0;

    always #20 clk_25 = ~clk_25;

    vga_sync_monitor_if bus ();

    vga_sync_monitor #(
        .H_TOTAL     (HT),
        .H_SYNC      (HS),
        .V_TOTAL     (VT),
        .V_SYNC      (VS),
        .H_TOL       (TOL),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit lk;
        int hp;
        int vl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Frame-level reference: 0 = search, 1 = check, 2 = locked
    int m_state  = 0;
    int m_cnt    = 0;
    bit fr_bad   = 1'b0;
    int fr_lines = 0;
    int fr_last  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h_period"}, 32'(bus.h_period), 0);
        check({tag, "_h_width"},  32'(bus.h_width),  0);
        check({tag, "_v_lines"},  32'(bus.v_lines),  0);
        check({tag, "_v_width"},  32'(bus.v_width),  0);
        check({tag, "_x_pos"},    32'(bus.x_pos),    0);
        check({tag, "_y_pos"},    32'(bus.y_pos),    0);
        check({tag, "_strobe"},   32'(bus.frame_strobe), 0);
        check({tag, "_locked"},   32'(bus.locked),   0);
    endtask

    function automatic bit off_tol(input int p);
        return (p > HT + TOL) || (p + TOL < HT);
    endfunction

    task automatic drive_line(input int period, input bit vlow);
        for (int p = 0; p < period; p++) begin
            @(negedge clk_25);
            bus.h_sync_in = (p >= HS);
            bus.v_sync_in = !vlow;
        end
    endtask

    // Evaluate the frame just completed and queue what the DUT must report for it.
    task automatic frame_boundary();
        bit good;
        if (m_state == 0) begin
            m_state = 1;
            m_cnt   = 0;
        end else begin
            good = !fr_bad && (fr_lines == VT);
            if (m_state == 1) begin
                if (good) begin
                    m_cnt++;
                    if (m_cnt == LF) m_state = 2;
                end else begin
                    m_cnt = 0;
                end
            end else if (!good) begin
                m_state = 1;
                m_cnt   = 0;
            end
            sb.push_back('{lk: (m_state == 2), hp: fr_last, vl: fr_lines});
        end
    endtask

    task automatic gen_frame(input int nlines, input int period, input int odd_line, input int odd_period);
        int p;
        frame_boundary();
        fr_bad   = 1'b0;
        fr_lines = nlines;
        for (int l = 0; l < nlines; l++) begin
            p = (l == odd_line) ? odd_period : period;
            if (off_tol(p)) fr_bad = 1'b1;
            fr_last = p;
            drive_line(p, l < VS);
        end
    endtask

    always @(negedge clk_25) begin
        if (bus.frame_strobe === 1'b1) begin
            check("strobe_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_locked",   32'(bus.locked),   32'(mon_e.lk));
                check("sb_h_period", 32'(bus.h_period), mon_e.hp);
                check("sb_h_width",  32'(bus.h_width),  HS);
                check("sb_v_lines",  32'(bus.v_lines),  mon_e.vl);
                check("sb_v_width",  32'(bus.v_width),  VS);
            end
        end
    end

    initial begin
        bus.h_sync_in = 1'b1;
        bus.v_sync_in = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_25);
        check_reset_state("reset");
        reset_n = 1'b1;

        // Partial frame, then nominal frames until lock
        for (int l = 3; l < VT; l++) drive_line(HT, 1'b0);
        repeat (5) gen_frame(VT, HT, -1, 0);
        check("nom_locked",   32'(bus.locked),   1);
        check("nom_h_period", 32'(bus.h_period), HT);
        check("nom_h_width",  32'(bus.h_width),  HS);
        check("nom_v_lines",  32'(bus.v_lines),  VT);
        check("nom_v_width",  32'(bus.v_width),  VS);

        // Line period inside tolerance keeps lock
        repeat (2) gen_frame(VT, HT + 1, -1, 0);
        check("tol_h_period", 32'(bus.h_period), HT + 1);
        check("tol_locked",   32'(bus.locked),   1);

        // Line period outside tolerance never locks
        repeat (6) gen_frame(VT, HT + 5, -1, 0);
        check("oot_locked",   32'(bus.locked),   0);
        check("oot_h_period", 32'(bus.h_period), HT + 5);

        repeat (5) gen_frame(VT, HT, -1, 0);
        check("relock_locked", 32'(bus.locked), 1);

        // One stretched line (last of its frame) drops lock at that frame end
        gen_frame(VT, HT, VT - 1, HT + 50);
        repeat (5) gen_frame(VT, HT, -1, 0);
        check("stretch_relock", 32'(bus.locked), 1);

        // h_sync held high: lock lost exactly when x_pos saturates
        gen_frame(5, HT, -1, 0);
        check("hold_pre_locked", 32'(bus.locked), 1);
        @(negedge clk_25);
        bus.h_sync_in = 1'b0;
        bus.v_sync_in = 1'b1;
        for (int j = 0; j < 2100; j++) begin
            @(negedge clk_25);
            if (j == 2046) begin
                check("hold_2046_locked", 32'(bus.locked), 1);
                check("hold_2046_x_pos",  32'(bus.x_pos),  2046);
            end
            if (j == 2047) begin
                check("hold_2047_locked", 32'(bus.locked), 0);
                check("hold_2047_x_pos",  32'(bus.x_pos),  2047);
                check("hold_2047_y_pos",  32'(bus.y_pos),  5);
            end
            if (j == 2099) check("hold_sat_x_pos", 32'(bus.x_pos), 2047);
            bus.h_sync_in = !((j + 1) < HS);
        end
        m_state = 0;
        m_cnt   = 0;
        repeat (5) gen_frame(VT, HT, -1, 0);
        check("post_hold_locked", 32'(bus.locked), 1);

        // One-cycle reset while locked
        gen_frame(4, HT, -1, 0);
        check("pre_reset_locked", 32'(bus.locked), 1);
        @(negedge clk_25);
        reset_n = 1'b0;
        bus.h_sync_in = 1'b1;
        @(negedge clk_25);
        reset_n = 1'b1;
        check_reset_state("midreset");
        m_state = 0;
        m_cnt   = 0;
        for (int l = 4; l < VT; l++) drive_line(HT, 1'b0);
        repeat (5) gen_frame(VT, HT, -1, 0);
        check("post_reset_locked", 32'(bus.locked), 1);

        repeat (3) @(negedge clk_25);
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
